// File: rtl/axis_pkt_pkg.sv
// Shared types and helpers for the AXI-Stream frame header inserter.
// The header is the magic tag in the upper field above the per-frame sequence number.
package axis_pkt_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PAYLOAD = 1'b1
  } hdr_state_t;

  // Widest header word the helper can build; callers truncate to their beat width.
  localparam int HDR_MAX_W = 64;

  // Tag field width left above the sequence number.
  function automatic int hdr_tag_w(input int data_w, input int seq_w);
    return data_w - seq_w;
  endfunction

  function automatic logic [HDR_MAX_W-1:0] make_header(
    input logic [HDR_MAX_W-1:0] magic,
    input logic [HDR_MAX_W-1:0] seq,
    input int                   seq_w,
    input int                   tag_w
  );
    logic [HDR_MAX_W-1:0] seq_mask;
    logic [HDR_MAX_W-1:0] tag_mask;
    seq_mask = (HDR_MAX_W'(1) << seq_w) - HDR_MAX_W'(1);
    tag_mask = (HDR_MAX_W'(1) << tag_w) - HDR_MAX_W'(1);
    return ((magic & tag_mask) << seq_w) | (seq & seq_mask);
  endfunction

endpackage

// File: rtl/axis_header_inserter.sv
// Prepends a {MAGIC, seq} header beat to every tlast-delimited AXI-Stream frame
// and reports each completed frame's payload length. Output stage is fully registered.
module axis_header_inserter
  import axis_pkt_pkg::*;
#(
  parameter int          DATA_WIDTH = 16,
  parameter int          SEQ_WIDTH  = 8,
  parameter int unsigned MAGIC      = 'hA5,
  parameter int          LEN_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [SEQ_WIDTH-1:0]  seq_num,
  output logic                  frame_done,
  output logic [LEN_WIDTH-1:0]  last_frame_length
);

  localparam int TAG_W = hdr_tag_w(DATA_WIDTH, SEQ_WIDTH);

  hdr_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [SEQ_WIDTH-1:0]  seq_q, seq_d;
  logic                  done_q, done_d;
  logic                  free;
  logic [DATA_WIDTH-1:0] hdr_word;

  function automatic logic [LEN_WIDTH-1:0] sat_inc(input logic [LEN_WIDTH-1:0] v);
    return (&v) ? v : v + LEN_WIDTH'(1);
  endfunction

  assign free     = !tvalid_q || m_axis_tready;
  assign hdr_word = DATA_WIDTH'(make_header(HDR_MAX_W'(MAGIC), HDR_MAX_W'(seq_q),
                                            SEQ_WIDTH, TAG_W));

  always_comb begin
    state_d       = state_q;
    tdata_d       = tdata_q;
    tlast_d       = tlast_q;
    // A completed downstream handshake empties the register unless reloaded below.
    tvalid_d      = tvalid_q && !m_axis_tready;
    cnt_d         = cnt_q;
    len_d         = len_q;
    seq_d         = seq_q;
    done_d        = 1'b0;
    s_axis_tready = 1'b0;
    case (state_q)
      IDLE: begin
        // The header goes out without consuming the waiting input beat.
        if (enable && s_axis_tvalid && free) begin
          tdata_d  = hdr_word;
          tlast_d  = 1'b0;
          tvalid_d = 1'b1;
          cnt_d    = '0;
          state_d  = PAYLOAD;
        end
      end
      PAYLOAD: begin
        s_axis_tready = free;
        if (s_axis_tvalid && free) begin
          tdata_d  = s_axis_tdata;
          tlast_d  = s_axis_tlast;
          tvalid_d = 1'b1;
          cnt_d    = sat_inc(cnt_q);
          if (s_axis_tlast) begin
            len_d   = sat_inc(cnt_q);
            done_d  = 1'b1;
            seq_d   = seq_q + SEQ_WIDTH'(1);
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      cnt_q    <= '0;
      len_q    <= '0;
      seq_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      seq_q    <= seq_d;
      done_q   <= done_d;
    end
  end

  assign m_axis_tdata      = tdata_q;
  assign m_axis_tvalid     = tvalid_q;
  assign m_axis_tlast      = tlast_q;
  assign seq_num           = seq_q;
  assign frame_done        = done_q;
  assign last_frame_length = len_q;

endmodule

// File: tb/tb_axis_header_inserter.sv
// Bench for axis_header_inserter: a default-width instance and a narrow instance
// (8-bit beats, 2-bit sequence, 3-bit length) share one stimulus stream.
module tb_axis_header_inserter;

  logic        aclk     = 1'b0;
  logic        aresetn  = 1'b0;
  logic        enable   = 1'b0;
  logic [15:0] s_tdata  = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast  = 1'b0;
  logic        m_tready = 1'b1;

  logic        s_tready1, m1_tvalid, m1_tlast, done1;
  logic [15:0] m1_tdata, len1;
  logic [7:0]  seq1;
  logic        s_tready2, m2_tvalid, m2_tlast, done2;
  logic [7:0]  m2_tdata;
  logic [1:0]  seq2;
  logic [2:0]  len2;

  axis_header_inserter #(.DATA_WIDTH(16), .SEQ_WIDTH(8), .MAGIC('hA5), .LEN_WIDTH(16)) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready1),
    .m_axis_tdata(m1_tdata), .m_axis_tvalid(m1_tvalid), .m_axis_tlast(m1_tlast),
    .m_axis_tready(m_tready),
    .seq_num(seq1), .frame_done(done1), .last_frame_length(len1)
  );

  axis_header_inserter #(.DATA_WIDTH(8), .SEQ_WIDTH(2), .MAGIC('hA5), .LEN_WIDTH(3)) dut2 (
    .aclk(aclk), .aresetn(aresetn), .enable(enable),
    .s_axis_tdata(s_tdata[7:0]), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready2),
    .m_axis_tdata(m2_tdata), .m_axis_tvalid(m2_tvalid), .m_axis_tlast(m2_tlast),
    .m_axis_tready(m_tready),
    .seq_num(seq2), .frame_done(done2), .last_frame_length(len2)
  );

  always #5 aclk = ~aclk;

  typedef struct { logic [15:0] d; logic l; } beat_t;
  typedef struct { int len; int frames; } done_t;
  typedef struct {
    logic en, v; logic [15:0] d; logic l;
    logic e_sr, e_mv; logic [15:0] e_md; logic e_ml, e_done; logic [15:0] e_len; logic [7:0] e_seq;
  } vec_t;

  beat_t       exp1[$], exp2[$];
  done_t       lq[$];
  logic [15:0] fb[64];
  int          frames, n_checks, n_fail, bubbles;
  bit          sb_on, bp_on;
  vec_t        tbl[7];

  beat_t       mb;
  done_t       md;
  logic        pstall1, pstall2, pl1, pl2;
  logic [15:0] pd1;
  logic [7:0]  pd2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic flag(input string name, input logic [63:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: actual %0h, required nothing (t=%0t)", name, act, $time);
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Header words from the rules: tag above seq, tag truncated to the field, seq mod 2^SEQ.
  function automatic logic [15:0] hdr1(input int f);
    return 16'((32'hA5 << 8) | (f % 256));
  endfunction

  function automatic logic [7:0] hdr2(input int f);
    return 8'(((32'hA5 % 64) << 2) | (f % 4));
  endfunction

  function automatic vec_t mk(input logic en, v, input logic [15:0] d, input logic l,
                              input logic sr, mv, input logic [15:0] md_, input logic ml, dn,
                              input logic [15:0] ln, input logic [7:0] sq);
    vec_t r;
    r.en = en; r.v = v; r.d = d; r.l = l; r.e_sr = sr; r.e_mv = mv; r.e_md = md_;
    r.e_ml = ml; r.e_done = dn; r.e_len = ln; r.e_seq = sq;
    return r;
  endfunction

  task automatic plan_frame(input int len);
    beat_t b;
    done_t dd;
    b.d = hdr1(frames); b.l = 1'b0; exp1.push_back(b);
    b.d = {8'h00, hdr2(frames)};    exp2.push_back(b);
    for (int i = 0; i < len; i++) begin
      fb[i] = 16'($urandom);
      b.l = (i == len - 1);
      b.d = fb[i];                exp1.push_back(b);
      b.d = {8'h00, fb[i][7:0]};  exp2.push_back(b);
    end
    frames++;
    dd.len = len; dd.frames = frames;
    lq.push_back(dd);
  endtask

  // Entered and left at posedge+1.
  task automatic drive_frame(input int len, input bit gaps);
    bit acc;
    int cyc;
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0;
        @(posedge aclk); #1;
      end
      s_tvalid = 1'b1; s_tdata = fb[i]; s_tlast = (i == len - 1);
      acc = 1'b0; cyc = 0;
      while (!acc) begin
        @(negedge aclk);
        if (s_tready1) acc = 1'b1; else bubbles++;
        @(posedge aclk); #1;
        cyc++;
        if (!acc && cyc > 200) begin
          flag("drive_timeout", 64'(i));
          s_tvalid = 1'b0; s_tlast = 1'b0;
          return;
        end
      end
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic send_frame(input int len, input bit gaps);
    plan_frame(len);
    drive_frame(len, gaps);
  endtask

  always @(posedge aclk) begin
    #1;
    m_tready = bp_on ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Scoreboard and stall-stability monitor.
  always @(negedge aclk) begin
    if (!sb_on) begin
      pstall1 = 1'b0; pstall2 = 1'b0;
    end else begin
      if (pstall1) begin
        chk("stall_valid1", 64'(m1_tvalid), 64'(1));
        chk("stall_data1", 64'(m1_tdata), 64'(pd1));
        chk("stall_last1", 64'(m1_tlast), 64'(pl1));
      end
      if (pstall2) begin
        chk("stall_valid2", 64'(m2_tvalid), 64'(1));
        chk("stall_data2", 64'(m2_tdata), 64'(pd2));
        chk("stall_last2", 64'(m2_tlast), 64'(pl2));
      end
      if (m1_tvalid && m_tready) begin
        if (exp1.size() == 0) flag("extra_beat1", 64'(m1_tdata));
        else begin
          mb = exp1.pop_front();
          chk("beat_data1", 64'(m1_tdata), 64'(mb.d));
          chk("beat_last1", 64'(m1_tlast), 64'(mb.l));
        end
      end
      if (m2_tvalid && m_tready) begin
        if (exp2.size() == 0) flag("extra_beat2", 64'(m2_tdata));
        else begin
          mb = exp2.pop_front();
          chk("beat_data2", 64'(m2_tdata), 64'(mb.d));
          chk("beat_last2", 64'(m2_tlast), 64'(mb.l));
        end
      end
      if (done1 || done2) begin
        if (lq.size() == 0) flag("extra_done", 64'({done1, done2}));
        else begin
          md = lq.pop_front();
          chk("done_both", 64'({done1, done2}), 64'(2'b11));
          chk("frame_len1", 64'(len1), 64'(sat(md.len, 65535)));
          chk("frame_len2", 64'(len2), 64'(sat(md.len, 7)));
          chk("seq_after1", 64'(seq1), 64'(md.frames % 256));
          chk("seq_after2", 64'(seq2), 64'(md.frames % 4));
        end
      end
      pstall1 = m1_tvalid && !m_tready; pd1 = m1_tdata; pl1 = m1_tlast;
      pstall2 = m2_tvalid && !m_tready; pd2 = m2_tdata; pl2 = m2_tlast;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    n_checks = 0; n_fail = 0; frames = 0; bubbles = 0; sb_on = 1'b0; bp_on = 1'b0;

    tbl[0] = mk(1, 1, 16'h0001, 0,  0, 0, 16'h0000, 0, 0, 16'd0, 8'd0);
    tbl[1] = mk(1, 1, 16'h0001, 0,  1, 1, 16'hA500, 0, 0, 16'd0, 8'd0);
    tbl[2] = mk(1, 1, 16'h0002, 0,  1, 1, 16'h0001, 0, 0, 16'd0, 8'd0);
    tbl[3] = mk(1, 1, 16'h0003, 0,  1, 1, 16'h0002, 0, 0, 16'd0, 8'd0);
    tbl[4] = mk(1, 1, 16'h0004, 1,  1, 1, 16'h0003, 0, 0, 16'd0, 8'd0);
    tbl[5] = mk(1, 0, 16'h0000, 0,  0, 1, 16'h0004, 1, 1, 16'd4, 8'd1);
    tbl[6] = mk(1, 0, 16'h0000, 0,  0, 0, 16'h0000, 0, 0, 16'd4, 8'd1);

    #22;
    chk("rst_tvalid", 64'(m1_tvalid), 64'(0));
    chk("rst_tlast", 64'(m1_tlast), 64'(0));
    chk("rst_tdata", 64'(m1_tdata), 64'(0));
    chk("rst_seq", 64'(seq1), 64'(0));
    chk("rst_done", 64'(done1), 64'(0));
    chk("rst_len", 64'(len1), 64'(0));
    chk("rst_tvalid2", 64'(m2_tvalid), 64'(0));
    @(negedge aclk); aresetn = 1'b1;
    @(posedge aclk); #1;

    // 4-beat frame, cycle by cycle.
    for (int i = 0; i < 7; i++) begin
      enable = tbl[i].en; s_tvalid = tbl[i].v; s_tdata = tbl[i].d; s_tlast = tbl[i].l;
      @(negedge aclk);
      chk($sformatf("tbl%0d_sready", i), 64'(s_tready1), 64'(tbl[i].e_sr));
      chk($sformatf("tbl%0d_mvalid", i), 64'(m1_tvalid), 64'(tbl[i].e_mv));
      if (tbl[i].e_mv) begin
        chk($sformatf("tbl%0d_mdata", i), 64'(m1_tdata), 64'(tbl[i].e_md));
        chk($sformatf("tbl%0d_mlast", i), 64'(m1_tlast), 64'(tbl[i].e_ml));
      end
      chk($sformatf("tbl%0d_done", i), 64'(done1), 64'(tbl[i].e_done));
      chk($sformatf("tbl%0d_len", i), 64'(len1), 64'(tbl[i].e_len));
      chk($sformatf("tbl%0d_seq", i), 64'(seq1), 64'(tbl[i].e_seq));
      @(posedge aclk); #1;
    end
    frames = 1;
    sb_on  = 1'b1;

    // enable low holds off the frame start; raising it yields the header next cycle.
    plan_frame(1);
    enable = 1'b0; s_tvalid = 1'b1; s_tdata = fb[0]; s_tlast = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      chk("en_off_mvalid", 64'(m1_tvalid), 64'(0));
      chk("en_off_sready", 64'(s_tready1), 64'(0));
      @(posedge aclk); #1;
    end
    enable = 1'b1;
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("en_on_hdr_valid", 64'(m1_tvalid), 64'(1));
    chk("en_on_hdr_data", 64'(m1_tdata), 64'(hdr1(1)));
    chk("en_on_sready", 64'(s_tready1), 64'(1));
    @(posedge aclk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0;

    // Back-to-back single-beat frames: one input bubble per frame.
    bubbles = 0;
    for (int i = 0; i < 3; i++) send_frame(1, 1'b0);
    chk("bubbles_3x1", 64'(bubbles), 64'(3));

    // Random backpressure and upstream gaps, then a long frame past the narrow length limit.
    bp_on = 1'b1;
    for (int i = 0; i < 20; i++) send_frame($urandom_range(1, 9), 1'b1);
    send_frame(12, 1'b1);
    bp_on = 1'b0;
    for (int c = 0; c < 200 && (exp1.size() != 0 || exp2.size() != 0 || lq.size() != 0); c++)
      @(posedge aclk);
    #1;
    chk("drain_exp1", 64'(exp1.size()), 64'(0));
    chk("drain_exp2", 64'(exp2.size()), 64'(0));
    chk("drain_done", 64'(lq.size()), 64'(0));

    // Reset after the second payload beat of a 5-beat frame.
    sb_on = 1'b0;
    s_tvalid = 1'b1; s_tdata = 16'h0101; s_tlast = 1'b0; acc = 0;
    for (int c = 0; c < 20 && acc < 2; c++) begin
      @(negedge aclk);
      if (s_tready1) acc++;
      @(posedge aclk); #1;
      s_tdata = 16'(16'h0101 + acc);
    end
    chk("rst_pre_beats", 64'(acc), 64'(2));
    chk("rst_pre_valid", 64'(m1_tvalid), 64'(1));
    #2; aresetn = 1'b0; #1;
    chk("mid_rst_tvalid", 64'(m1_tvalid), 64'(0));
    chk("mid_rst_tdata", 64'(m1_tdata), 64'(0));
    chk("mid_rst_tlast", 64'(m1_tlast), 64'(0));
    chk("mid_rst_seq", 64'(seq1), 64'(0));
    chk("mid_rst_len", 64'(len1), 64'(0));
    chk("mid_rst_sready", 64'(s_tready1), 64'(0));
    chk("mid_rst_tvalid2", 64'(m2_tvalid), 64'(0));
    @(negedge aclk);
    aresetn = 1'b1; s_tvalid = 1'b0;
    exp1.delete(); exp2.delete(); lq.delete(); frames = 0;
    @(posedge aclk); #1;
    sb_on = 1'b1;
    send_frame(3, 1'b0);
    send_frame(2, 1'b0);
    for (int c = 0; c < 50 && (exp1.size() != 0 || lq.size() != 0); c++) @(posedge aclk);
    #1;
    chk("post_rst_drain", 64'(exp1.size() + lq.size()), 64'(0));
    chk("post_rst_seq", 64'(seq1), 64'(2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_header_inserter.md
Name: axis_header_inserter

Overview:
- Downstream neighbour of the frame packetizer; consumes its tlast-delimited AXI-Stream frames.
- Prepends one header beat to every frame. The header carries a fixed magic tag and a wrapping per-frame sequence number.
- Reports the payload length of each completed frame.
- Output stage is fully registered. It feeds link or DMA logic that needs self-describing frames.

Parameters:
- DATA_WIDTH, 16: payload and header beat width in bits. Must be greater than SEQ_WIDTH.
- SEQ_WIDTH, 8: sequence number width. The number wraps modulo 2^SEQ_WIDTH.
- MAGIC, 'hA5: header tag. Occupies header bits [DATA_WIDTH-1:SEQ_WIDTH], truncated or zero-extended to DATA_WIDTH-SEQ_WIDTH bits.
- LEN_WIDTH, 16: payload beat counter and length report width.

Ports:
- aclk, input, 1: clock.
- aresetn, input, 1: reset. Asynchronous assertion, active-low. Clears all state.
- enable, input, 1: when low, no new frame is started. A frame already in progress always completes.
- s_axis_tdata, input, DATA_WIDTH: payload in.
- s_axis_tvalid, input, 1: upstream valid.
- s_axis_tlast, input, 1: last payload beat of the frame.
- s_axis_tready, output, 1: upstream ready. Combinational.
- m_axis_tdata, output, DATA_WIDTH: header or payload out. Registered.
- m_axis_tvalid, output, 1: registered.
- m_axis_tlast, output, 1: registered. Never set on a header beat.
- m_axis_tready, input, 1: downstream ready.
- seq_num, output, SEQ_WIDTH: sequence number of the next or current frame.
- frame_done, output, 1: one-cycle pulse when the last payload beat is accepted from upstream.
- last_frame_length, output, LEN_WIDTH: payload beat count of the most recently completed frame.

Behaviour:
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, seq_num=0, frame_done=0, last_frame_length=0. State=IDLE, beat counter=0.
- Output register is "free" when !m_axis_tvalid || m_axis_tready.
- m_axis_tvalid deasserts the cycle after a handshake with nothing new loaded.
- While m_axis_tvalid=1 && m_axis_tready=0, m_axis_tdata and m_axis_tlast are held stable (AXI rule).
- IDLE state:
  - s_axis_tready=0.
  - If enable && s_axis_tvalid && free: load header {MAGIC, seq_num} with tlast=0, clear the beat counter, go to PAYLOAD.
  - The header is loaded without consuming the input beat.
- PAYLOAD state:
  - s_axis_tready = free.
  - On an input handshake: load s_axis_tdata/s_axis_tlast into the output register and increment the beat counter, saturating at all-ones.
  - If s_axis_tlast is also set: last_frame_length <= counter+1 (saturating), frame_done=1 for one cycle, seq_num <= seq_num+1 (wraps), go to IDLE.
- Latency:
  - Header appears on m_axis one cycle after the first qualifying cycle in IDLE.
  - Each payload beat appears one cycle after its acceptance.
- Throughput: 1 beat/cycle within a frame. One header bubble on the input per frame (N+1 output beats per N-beat frame).
- Single-beat frame: output is header, then one payload beat with tlast=1; last_frame_length=1.
- enable falling mid-frame: no effect on the current frame. Sampled only in IDLE.
- Upstream gaps (tvalid low mid-frame): the output register drains normally. State and counter are held.
- Reset mid-frame:
  - Outputs and state clear immediately. The downstream sees a truncated frame without tlast; this is accepted behaviour.
  - The next upstream beat after reset release is treated as a new frame start and receives a header with seq 0.
- Sequence wrap: after frame number 2^SEQ_WIDTH-1 the header seq returns to 0. No other side effect.
- Length saturation: frames longer than 2^LEN_WIDTH-1 report all-ones. Data still passes unmodified.
- Simultaneous downstream handshake and new load in the same cycle: the register is overwritten with no bubble.

Decomposition:
- Package axis_pkt_pkg holds:
  - typedef enum {IDLE, PAYLOAD} hdr_state_t;
  - function make_header(magic, seq) returning the DATA_WIDTH header word.
  - localparam header tag field width.
- No sub-module. The output register is local, so the existing skid buffer is not instantiated.
- The s_axis_tready→m_axis_tready combinational path is accepted.

Test Plan:
- Frame of 4 beats (0x0001..0x0004, tlast on 4th), m_axis_tready=1, enable=1 → m_axis: 0xA500, 0x0001, 0x0002, 0x0003, 0x0004 (tlast), frame_done pulse, last_frame_length=4, seq_num=1.
- Three back-to-back single-beat frames → headers 0xA500, 0xA501, 0xA502, each followed by one tlast beat; exactly one input-ready bubble per frame.
- Random m_axis_tready backpressure (50%) over 20 frames of length 1..9 → data and tlast stable while stalled, no beat lost or duplicated, each header seq increments by 1.
- enable=0 with s_axis_tvalid=1 held for 10 cycles → m_axis_tvalid stays 0 and s_axis_tready stays 0. Raising enable → header within 1 cycle.
- aresetn pulsed low after beat 2 of a 5-beat frame → outputs 0 immediately; next frame header is 0xA500.
- SEQ_WIDTH=2, 5 frames → header seq sequence 0,1,2,3,0.
